instr_sequencer: RTL and testbench

- Fetch/sequence engine on the other end of the control unit's IR/CU_en interface.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake, latches IR and pulses CU_en for one cycle.
- Consumes the control unit's registered bra/BADR/hlt outputs to update the PC, halt, or continue.
- Owns the PC and the fetch-decode-execute state machine for the 16-bit processor.

---
 rtl/instr_sequencer.sv | 149 ++++++++++++++
 tb/tb_instr_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/sequence engine for the 16-bit processor.
//
// Owns the program counter and the fetch-decode-execute state machine. It
// fetches one instruction per pass over a req/ack handshake, latches it into
// the instruction register, pulses the decode enable for one cycle, and then
// applies the control unit's branch/halt result to the program counter.
//
// Ports:
//   i_clk         system clock, all state on the rising edge
//   i_rst         synchronous active-high reset
//   i_start       leaves IDLE and begins fetching at pc = 0
//   o_imem_req    instruction fetch request
//   o_imem_addr   fetch address (always equals pc)
//   i_imem_ack    fetch complete, i_imem_data valid this cycle
//   i_imem_data   fetched instruction
//   o_ir          instruction register to the control unit
//   o_cu_en       one-cycle decode enable to the control unit
//   i_bra         branch taken (control unit, registered)
//   i_badr        branch target (control unit, registered)
//   i_hlt         halt request (control unit, registered)
//   i_exec_busy   multi-cycle execute in progress; stalls sequencing
//   o_pc          current program counter
//   o_halted      sticky halt indicator
//   o_fault       sticky fetch-timeout indicator

module instr_sequencer #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic [INSTR_W-1:0] o_ir,
  output logic               o_cu_en,
  input  logic               i_bra,
  input  logic [ADDR_W-1:0]  i_badr,
  input  logic               i_hlt,
  input  logic               i_exec_busy,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_halted,
  output logic               o_fault
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt,
    StFault
  } state_e;

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned   CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  state_e               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic                 r_imem_req;
  logic                 r_cu_en;
  logic                 r_halted;
  logic                 r_fault;
  logic [CntW-1:0]      r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_ir       <= '0;
      r_imem_req <= 1'b0;
      r_cu_en    <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state    <= StFetch;
            r_imem_req <= 1'b1;
            r_cnt      <= '0;
          end
        end

        StFetch: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (i_imem_ack) begin
            r_ir       <= i_imem_data;
            r_imem_req <= 1'b0;
            r_cnt      <= '0;
            r_cu_en    <= 1'b1;
            r_state    <= StDecode;
          end else if (r_cnt == CntMax) begin
            r_imem_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= StFault;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        StDecode: begin
          r_cu_en <= 1'b0;
          r_state <= StExec;
        end

        StExec: begin
          if (!i_exec_busy) begin
            // The control unit raises bra alongside hlt; halt takes priority.
            if (i_hlt) begin
              r_halted <= 1'b1;
              r_state  <= StHalt;
            end else begin
              r_pc       <= i_bra ? i_badr : r_pc + ADDR_W'(1);
              r_imem_req <= 1'b1;
              r_cnt      <= '0;
              r_state    <= StFetch;
            end
          end
        end

        // Terminal states: only reset leaves them.
        StHalt:  r_state <= StHalt;
        StFault: r_state <= StFault;

        default: begin
          r_state    <= StIdle;
          r_imem_req <= 1'b0;
          r_cu_en    <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;
  assign o_ir        = r_ir;
  assign o_cu_en     = r_cu_en;
  assign o_pc        = r_pc;
  assign o_halted    = r_halted;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a cycle-level reference model and a
// scripted memory responder.

module tb_instr_sequencer;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned TIMEOUT = 8;
  localparam int          NWORDS  = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_data = '0;
  logic [INSTR_W-1:0] ir;
  logic               cu_en;
  logic               bra = 1'b0;
  logic [ADDR_W-1:0]  badr = '0;
  logic               hlt = 1'b0;
  logic               exec_busy = 1'b0;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic               fault;

  instr_sequencer #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_imem_req (imem_req),
    .o_imem_addr(imem_addr),
    .i_imem_ack (imem_ack),
    .i_imem_data(imem_data),
    .o_ir       (ir),
    .o_cu_en    (cu_en),
    .i_bra      (bra),
    .i_badr     (badr),
    .i_hlt      (hlt),
    .i_exec_busy(exec_busy),
    .o_pc       (pc),
    .o_halted   (halted),
    .o_fault    (fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [INSTR_W-1:0] mem [NWORDS];
  int  mem_wait  = 0;     // cycles of req before ack
  bit  mem_dead  = 1'b0;  // never ack
  bit  force_ack = 1'b0;  // raw ack regardless of req
  int  wait_cnt  = 0;

  always @(posedge clk) begin
    #1;
    if (force_ack) begin
      imem_ack  = 1'b1;
      imem_data = 16'hDEAD;
    end else if (imem_req && !mem_dead) begin
      if (wait_cnt >= mem_wait) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      if (!imem_req) wait_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  // Expected visible outputs, plus bookkeeping: how long the current request
  // has been outstanding and whether an instruction is awaiting its result.
  logic               e_req = 1'b0, e_cu = 1'b0, e_halted = 1'b0, e_fault = 1'b0;
  logic [INSTR_W-1:0] e_ir = '0;
  int                 e_pc = 0;
  int                 req_age = 0;
  bit                 awaiting_result = 1'b0;
  bit                 model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      e_req = 0; e_cu = 0; e_halted = 0; e_fault = 0; e_ir = '0; e_pc = 0;
      req_age = 0; awaiting_result = 0; model_valid = 1;
    end else if (e_halted || e_fault) begin
      // stuck until reset
    end else if (e_req) begin
      if (imem_ack) begin
        e_ir = imem_data; e_req = 0; e_cu = 1;
      end else if (req_age + 1 >= TIMEOUT) begin
        e_req = 0; e_fault = 1;
      end else begin
        req_age++;
      end
    end else if (e_cu) begin
      e_cu = 0; awaiting_result = 1;
    end else if (awaiting_result) begin
      if (!exec_busy) begin
        awaiting_result = 0;
        if (hlt) e_halted = 1;
        else begin
          e_pc    = bra ? int'(badr) : (e_pc + 1) % NWORDS;
          e_req   = 1;
          req_age = 0;
        end
      end
    end else if (start) begin
      e_req = 1; req_age = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  int rise_cyc[$];
  bit prev_req = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (model_valid) begin
      check("imem_req", 32'(imem_req), 32'(e_req));
      check("imem_addr", 32'(imem_addr), 32'(e_pc));
      check("pc", 32'(pc), 32'(e_pc));
      check("cu_en", 32'(cu_en), 32'(e_cu));
      check("ir", 32'(ir), 32'(e_ir));
      check("halted", 32'(halted), 32'(e_halted));
      check("fault", 32'(fault), 32'(e_fault));
      if (imem_req && !prev_req) rise_cyc.push_back(cyc);
      prev_req = imem_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = INSTR_W'(16'hA000 + i);
    mem[0] = 16'h5801;
    mem[1] = 16'h5802;
    mem[2] = 16'h5803;

    // 1. reset and start
    do_reset();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_cu_en", 32'(cu_en), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    // ack with req low is ignored
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    tick();
    check("idle_ack_ir", 32'(ir), 32'h0);
    check("idle_ack_req", 32'(imem_req), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_req", 32'(imem_req), 32'h1);
    check("start_addr", 32'(imem_addr), 32'h000);

    // 2. sequential run, zero-wait memory
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", 32'(imem_addr), 32'(i));
      tick();
      check("seq_ir", 32'(ir), 32'h5801 + 32'(i));
      check("seq_cu_en_hi", 32'(cu_en), 32'h1);
      tick();
      check("seq_cu_en_lo", 32'(cu_en), 32'h0);
      tick();
    end
    check("seq_next_addr", 32'(imem_addr), 32'h3);
    check("seq_gap01", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
    check("seq_gap12", 32'(rise_cyc[2] - rise_cyc[1]), 32'd3);

    // 3. stall 4 cycles, then branch to 0x155
    exec_busy = 1'b1;
    tick();  // ack -> decode
    tick();  // exec
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_pc", 32'(pc), 32'h3);
      check("stall_req", 32'(imem_req), 32'h0);
    end
    exec_busy = 1'b0;
    bra = 1'b1;
    badr = 10'h155;
    tick();
    bra = 1'b0;
    check("bra_addr", 32'(imem_addr), 32'h155);
    check("bra_req", 32'(imem_req), 32'h1);

    // 4. halt wins over branch
    bra = 1'b1;
    hlt = 1'b1;
    badr = 10'h020;
    tick();
    tick();
    tick();
    bra = 1'b0;
    hlt = 1'b0;
    check("hlt_halted", 32'(halted), 32'h1);
    check("hlt_pc", 32'(pc), 32'h155);
    check("hlt_req", 32'(imem_req), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hlt_start_req", 32'(imem_req), 32'h0);
      check("hlt_start_halted", 32'(halted), 32'h1);
    end

    // 5. branch to 0x3FF, slow memory, wrap to 0x000
    do_reset();
    check("rst2_halted", 32'(halted), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    bra = 1'b1;
    badr = 10'h3FF;
    tick();  // decode
    mem_wait = 3;
    tick();  // exec
    tick();  // fetch at 0x3FF
    bra = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wait_req", 32'(imem_req), 32'h1);
      check("wait_addr", 32'(imem_addr), 32'h3FF);
      tick();
    end
    check("wait_ir", 32'(ir), 32'(mem[10'h3FF]));
    check("wait_cu_en", 32'(cu_en), 32'h1);
    tick();
    tick();
    check("wrap_addr", 32'(imem_addr), 32'h000);
    check("wrap_req", 32'(imem_req), 32'h1);
    mem_wait = 0;

    // 6. fetch timeout
    mem_dead = 1'b1;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("to_req", 32'(imem_req), 32'h1);
      check("to_fault_lo", 32'(fault), 32'h0);
      tick();
    end
    check("to_fault", 32'(fault), 32'h1);
    check("to_req_lo", 32'(imem_req), 32'h0);
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    tick();
    check("to_late_ack_ir", 32'(ir), 32'h0);
    check("to_late_ack_cu", 32'(cu_en), 32'h0);
    check("to_fault_sticky", 32'(fault), 32'h1);
    mem_dead = 1'b0;
    do_reset();
    check("to_rst_fault", 32'(fault), 32'h0);
    check("to_rst_pc", 32'(pc), 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
